// File: rtl/startup_pkg.sv
// Shared types for the startup reset sequencer: FSM state encoding and counter sizing.
package startup_pkg;

    typedef enum logic [2:0] {
        StReset    = 3'd0,
        StWaitLock = 3'd1,
        StHold     = 3'd2,
        StRelCore  = 3'd3,
        StWaitAck  = 3'd4,
        StRelIo    = 3'd5,
        StRun      = 3'd6
    } state_e;

    // One counter serves both the hold and ack phases, so size it for the larger terminal count.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned ack);
        int unsigned max_val;
        max_val = (hold > ack) ? hold : ack;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/startup_rst_seq_if.sv
// Handshake bundle between the startup sequencer and the logic it brings out of reset.
interface startup_rst_seq_if;

    logic       pll_locked_i;
    logic       init_done_i;
    logic       core_rst_n_o;
    logic       io_hold_o;
    logic       ready_o;
    logic       timeout_o;
    logic [2:0] state_o;

    modport master (
        output pll_locked_i,
        output init_done_i,
        input  core_rst_n_o,
        input  io_hold_o,
        input  ready_o,
        input  timeout_o,
        input  state_o
    );

    modport slave (
        input  pll_locked_i,
        input  init_done_i,
        output core_rst_n_o,
        output io_hold_o,
        output ready_o,
        output timeout_o,
        output state_o
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop bit synchronizer with asynchronous active-low clear.
module sync_ff #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/startup_rst_seq.sv
// Per-domain startup sequencer: waits for lock, holds core reset, releases core then I/O
// once the core acknowledges (or a timeout expires), and falls back on lock loss.
module startup_rst_seq
    import startup_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned HoldCycles = 16,
    parameter int unsigned AckTimeout = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    startup_rst_seq_if.slave  seq_io
);

    localparam int unsigned     CntW     = cnt_width(HoldCycles, AckTimeout);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] AckLast  = CntW'(AckTimeout - 1);
    localparam logic [CntW-1:0] CntMax   = '1;

    logic irst_n;
    logic lock_s;

    sync_ff #(
        .Stages (SyncStages)
    ) u_rst_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (1'b1),
        .q_o    (irst_n)
    );

    sync_ff #(
        .Stages (SyncStages)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (seq_io.pll_locked_i),
        .q_o    (lock_s)
    );

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            core_rst_n_q, core_rst_n_d;
    logic            io_hold_q, io_hold_d;
    logic            ready_q, ready_d;
    logic            timeout_q, timeout_d;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            StReset: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
            StWaitLock: begin
                cnt_d = '0;
                if (lock_s) state_d = StHold;
            end
            StHold: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRelCore;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRelCore: begin
                cnt_d   = '0;
                state_d = lock_s ? StWaitAck : StWaitLock;
            end
            StWaitAck: begin
                // Ack is checked before the timeout so a same-cycle ack never flags a timeout.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (seq_io.init_done_i) begin
                    state_d = StRelIo;
                    cnt_d   = '0;
                end else if (cnt_q == AckLast) begin
                    state_d   = StRelIo;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRelIo: begin
                state_d = lock_s ? StRun : StWaitLock;
            end
            StRun: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StReset;
                cnt_d   = '0;
            end
        endcase

        if (!irst_n) begin
            state_d = StReset;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state so they register together with it.
        core_rst_n_d = state_d inside {StRelCore, StWaitAck, StRelIo, StRun};
        io_hold_d    = !(state_d inside {StRelIo, StRun});
        ready_d      = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReset;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
            io_hold_q    <= 1'b1;
            ready_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_rst_n_q <= core_rst_n_d;
            io_hold_q    <= io_hold_d;
            ready_q      <= ready_d;
            timeout_q    <= timeout_d;
        end
    end

    assign seq_io.core_rst_n_o = core_rst_n_q;
    assign seq_io.io_hold_o    = io_hold_q;
    assign seq_io.ready_o      = ready_q;
    assign seq_io.timeout_o    = timeout_q;
    assign seq_io.state_o      = state_q;

endmodule

// File: tb/tb_startup_rst_seq.sv
// Directed bench for startup_rst_seq: a vector table for bring-up and lock loss, plus
// hand-written sequences for late lock, ack timeout, async reset mid-hold and ack-at-timeout.
module tb_startup_rst_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    startup_rst_seq_if seq_if ();

    startup_rst_seq u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_io (seq_if)
    );

    typedef struct {
        logic        rst_n;
        logic        lock;
        logic        ack;
        int unsigned n;
        logic        core;
        logic        hold;
        logic        ready;
        logic        tmo;
        logic [2:0]  state;
    } vec_t;

    vec_t vecs[19];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic core, input logic hold,
                              input logic ready, input logic tmo, input logic [2:0] state);
        check({tag, ".core"},  32'(seq_if.core_rst_n_o), 32'(core));
        check({tag, ".hold"},  32'(seq_if.io_hold_o),    32'(hold));
        check({tag, ".ready"}, 32'(seq_if.ready_o),      32'(ready));
        check({tag, ".tmo"},   32'(seq_if.timeout_o),    32'(tmo));
        check({tag, ".state"}, 32'(seq_if.state_o),      32'(state));
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_seq(input logic lock);
        seq_if.pll_locked_i = lock;
        seq_if.init_done_i  = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_core(input int max_cyc, output int n);
        n = 0;
        while (seq_if.core_rst_n_o !== 1'b1 && n < max_cyc) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        // rst_n, lock, ack, edges, core, hold, ready, tmo, state
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 3'd5};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 3'd6};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b1, 1'b0, 3'd6};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b1, 1'b0, 3'd6};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 7,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 2,  1'b1, 1'b0, 1'b0, 1'b0, 3'd5};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 3'd6};

        seq_if.pll_locked_i = 1'b1;
        seq_if.init_done_i  = 1'b0;
        #1;

        // Bring-up with lock already high, ack two cycles after core release, then lock loss.
        for (int i = 0; i < 19; i++) begin
            rst_n               = vecs[i].rst_n;
            seq_if.pll_locked_i = vecs[i].lock;
            seq_if.init_done_i  = vecs[i].ack;
            cyc(vecs[i].n);
            check_outs($sformatf("vec%0d", i), vecs[i].core, vecs[i].hold, vecs[i].ready,
                       vecs[i].tmo, vecs[i].state);
        end

        // Late lock: idle in WAIT_LOCK for 100 cycles, then sync + 16 hold + 1.
        reset_seq(1'b0);
        bad = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1);
            if (i >= 3 && (seq_if.state_o !== 3'd1 || seq_if.core_rst_n_o !== 1'b0)) bad++;
        end
        check("late_lock.wait_cycles_bad", 32'(bad), 32'd0);
        seq_if.pll_locked_i = 1'b1;
        wait_core(64, n);
        check("late_lock.core_latency", 32'(n), 32'd19);

        // Ack timeout, sticky flag across lock loss.
        reset_seq(1'b1);
        wait_core(64, n);
        check("tmo.core_latency", 32'(n), 32'd20);
        cyc(256);
        check_outs("tmo.last_wait", 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
        cyc(1);
        check_outs("tmo.rel_io", 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        cyc(1);
        check_outs("tmo.run", 1'b1, 1'b0, 1'b1, 1'b1, 3'd6);
        seq_if.pll_locked_i = 1'b0;
        cyc(3);
        check_outs("tmo.lock_loss", 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);

        // Relock, then async reset pulse mid-hold at counter 8.
        seq_if.pll_locked_i = 1'b1;
        cyc(3);
        check_outs("arst.hold_entry", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);
        cyc(8);
        rst_n = 1'b0;
        #1;
        check_outs("arst.async", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        #2;
        rst_n = 1'b1;
        cyc(4);
        check_outs("arst.hold_restart", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        cyc(15);
        check_outs("arst.hold_last", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        cyc(1);
        check_outs("arst.rel_core", 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);

        // Ack arriving on the very cycle the counter hits the timeout value.
        reset_seq(1'b1);
        wait_core(64, n);
        check("ackedge.core_latency", 32'(n), 32'd20);
        cyc(256);
        seq_if.init_done_i = 1'b1;
        cyc(1);
        check_outs("ackedge.rel_io", 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
        seq_if.init_done_i = 1'b0;
        cyc(1);
        check_outs("ackedge.run", 1'b1, 1'b0, 1'b1, 1'b0, 3'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
